// File: rtl/hex_pio_write_arbiter_if.sv
// Requester-side and PIO s1-side signals of the hex display write arbiter.
// master: the arbiter's view; slave: the requesters plus the PIO slave model.
interface hex_pio_write_arbiter_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]    req;
   logic [NUM_REQ*32-1:0] req_data;
   logic [NUM_REQ-1:0]    grant;
   logic                  busy;
   logic [1:0]            pio_address;
   logic                  pio_chipselect;
   logic                  pio_write_n;
   logic [31:0]           pio_writedata;
   logic [31:0]           pio_readdata;
   logic                  err_mismatch;

   modport master (
      input  req, req_data, pio_readdata,
      output grant, busy, pio_address, pio_chipselect, pio_write_n, pio_writedata, err_mismatch
   );

   modport slave (
      output req, req_data, pio_readdata,
      input  grant, busy, pio_address, pio_chipselect, pio_write_n, pio_writedata, err_mismatch
   );
endinterface

// File: rtl/hex_pio_write_arbiter.sv
// Round-robin arbiter issuing one zero-wait write per grant to a shared 32-bit PIO, then dwelling.
// Define HEX_PIO_ARB_READBACK_EN to add a VERIFY read-back cycle with a sticky mismatch flag.
module hex_pio_write_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int HOLD_CYCLES = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   hex_pio_write_arbiter_if.master  bus
);

   localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_VERIFY, S_HOLD} state_t;

   state_t             state_q, state_d;
   logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]    sel_id_q, sel_id_d;
   logic [31:0]        sel_data_q, sel_data_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               err_q, err_d;
   logic [ID_W-1:0]    pick_id;
   logic               pick_vld;
   logic [NUM_REQ-1:0] grant_d;

   function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int k);
      return ID_W'((int'(base) + k) % NUM_REQ);
   endfunction

   // Walk from the farthest offset down so the nearest requester to rr_ptr wins.
   always_comb begin
      pick_vld = 1'b0;
      pick_id  = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (bus.req[wrap_add(rr_ptr_q, k)]) begin
            pick_vld = 1'b1;
            pick_id  = wrap_add(rr_ptr_q, k);
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      sel_id_d   = sel_id_q;
      sel_data_d = sel_data_q;
      cnt_d      = cnt_q;
      err_d      = err_q;
      case (state_q)
         S_IDLE: begin
            if (pick_vld) begin
               sel_id_d   = pick_id;
               sel_data_d = bus.req_data[int'(pick_id)*32 +: 32];
               state_d    = S_WRITE;
            end
         end
         S_WRITE: begin
            rr_ptr_d = wrap_add(sel_id_q, 1);
`ifdef HEX_PIO_ARB_READBACK_EN
            state_d  = S_VERIFY;
`else
            if (HOLD_CYCLES == 0) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_HOLD;
               cnt_d   = CNT_W'(HOLD_CYCLES);
            end
`endif
         end
         S_VERIFY: begin
`ifdef HEX_PIO_ARB_READBACK_EN
            if (bus.pio_readdata != sel_data_q) err_d = 1'b1;
            if (HOLD_CYCLES == 0) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_HOLD;
               cnt_d   = CNT_W'(HOLD_CYCLES);
            end
`else
            state_d = S_IDLE;
`endif
         end
         S_HOLD: begin
            if (cnt_q <= CNT_W'(1)) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         rr_ptr_q   <= '0;
         sel_id_q   <= '0;
         sel_data_q <= '0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         sel_id_q   <= sel_id_d;
         sel_data_q <= sel_data_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      grant_d = '0;
      if (state_q == S_WRITE) grant_d[sel_id_q] = 1'b1;
   end

   // Strobes decode straight from state so a reset edge clears them immediately.
   assign bus.grant          = grant_d;
   assign bus.busy           = (state_q != S_IDLE);
   assign bus.pio_address    = 2'b00;
   assign bus.pio_chipselect = (state_q == S_WRITE) || (state_q == S_VERIFY);
   assign bus.pio_write_n    = (state_q != S_WRITE);
   assign bus.pio_writedata  = sel_data_q;
   assign bus.err_mismatch   = err_q;

`ifndef HEX_PIO_ARB_READBACK_EN
   logic unused_readdata;
   assign unused_readdata = ^bus.pio_readdata;
`endif

endmodule

// File: tb/tb_hex_pio_write_arbiter.sv
// Scoreboard bench for hex_pio_write_arbiter: expected writes are queued as stimulus is driven
// and popped when the PIO write strobe is observed.
module tb_hex_pio_write_arbiter;

   localparam int NR = 4;
   localparam int HC = 4;
`ifdef HEX_PIO_ARB_READBACK_EN
   localparam int RB = 1;
`else
   localparam int RB = 0;
`endif
   localparam int PERIOD = 2 + RB + HC;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   hex_pio_write_arbiter_if #(.NUM_REQ(NR)) bus_if ();

   hex_pio_write_arbiter #(.NUM_REQ(NR), .HOLD_CYCLES(HC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   typedef struct {
      int          id;
      logic [31:0] data;
      int          gap;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   int   last_strobe = 0;
   logic verify_next = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Monitor: every write strobe must match the head of the scoreboard.
   always @(negedge clk) begin
      if (reset) begin
         verify_next = 1'b0;
      end else begin
         if (bus_if.pio_write_n == 1'b0) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_write", 32'(sb_q.size()), 32'd1);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               chk("grant", 32'(bus_if.grant), 32'(1 << e.id));
               chk("writedata", bus_if.pio_writedata, e.data);
               chk("write_cs", 32'(bus_if.pio_chipselect), 32'd1);
               chk("write_addr", 32'(bus_if.pio_address), 32'd0);
               if (e.gap > 0) chk("strobe_gap", 32'(cyc - last_strobe), 32'(e.gap));
            end
            last_strobe = cyc;
         end else begin
            chk("grant_idle", 32'(bus_if.grant), 32'd0);
            chk("cs_idle", 32'(bus_if.pio_chipselect), 32'(verify_next));
         end
         verify_next = (bus_if.pio_write_n == 1'b0) && (RB != 0);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_data(input int i, input logic [31:0] d);
      bus_if.req_data[32*i +: 32] = d;
   endtask

   task automatic push(input int id, input logic [31:0] d, input int gap);
      exp_t e;
      e.id = id;
      e.data = d;
      e.gap = gap;
      sb_q.push_back(e);
   endtask

   task automatic wait_q(input int left, input int budget);
      int n;
      n = 0;
      while (sb_q.size() > left && n < budget) begin
         tick(1);
         n++;
      end
      if (sb_q.size() > left) begin
         chk("sb_timeout", 32'(sb_q.size()), 32'(left));
         sb_q.delete();
      end
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      bus_if.req = '0;
      tick(n);
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int nb;
      reset = 1'b1;
      bus_if.req = '0;
      bus_if.req_data = '0;
      bus_if.pio_readdata = 32'hDEAD_BEEF;

      // Reset with all requests asserted
      bus_if.req = 4'hF;
      tick(2);
      chk("rst_grant", 32'(bus_if.grant), 32'd0);
      chk("rst_busy", 32'(bus_if.busy), 32'd0);
      chk("rst_cs", 32'(bus_if.pio_chipselect), 32'd0);
      chk("rst_write_n", 32'(bus_if.pio_write_n), 32'd1);
      chk("rst_err", 32'(bus_if.err_mismatch), 32'd0);
      chk("rst_wdata", bus_if.pio_writedata, 32'd0);
      chk("rst_addr", 32'(bus_if.pio_address), 32'd0);
      bus_if.req = '0;
      reset = 1'b0;
      tick(2);

      // Single request from requester 1
      set_data(1, 32'h0000_00F9);
      push(1, 32'h0000_00F9, 0);
      bus_if.req = 4'b0010;
      tick(1);
      bus_if.req = '0;
      nb = 0;
      repeat (10) begin
         @(negedge clk);
         nb += int'(bus_if.busy);
      end
      chk("busy_cycles", 32'(nb), 32'(HC + 1 + RB));
      wait_q(0, 20);
      tick(2);

      // All requesting: strict rotation 0,1,2,3,0
      do_reset(2);
      for (int i = 0; i < NR; i++) set_data(i, 32'h10 + 32'(i));
      push(0, 32'h10, 0);
      push(1, 32'h11, PERIOD);
      push(2, 32'h12, PERIOD);
      push(3, 32'h13, PERIOD);
      push(0, 32'h10, PERIOD);
      bus_if.req = 4'hF;
      wait_q(0, 100);
      bus_if.req = '0;
      chk("wdata_holds", bus_if.pio_writedata, 32'h10);
      tick(PERIOD + 2);

      // Requester 2 arrives during requester 0's dwell and is served next
      do_reset(1);
      set_data(0, 32'hA0);
      set_data(2, 32'hA2);
      push(0, 32'hA0, 0);
      push(2, 32'hA2, PERIOD);
      push(0, 32'hA0, PERIOD);
      bus_if.req = 4'b0001;
      wait_q(2, 20);
      tick(1);
      bus_if.req[2] = 1'b1;
      wait_q(1, 40);
      bus_if.req[2] = 1'b0;
      wait_q(0, 40);
      bus_if.req = '0;
      tick(PERIOD + 2);

      // Reset during dwell restarts rotation at requester 0
      do_reset(1);
      set_data(1, 32'hB1);
      push(1, 32'hB1, 0);
      bus_if.req = 4'b0010;
      wait_q(0, 20);
      bus_if.req = '0;
      tick(1);
      chk("in_hold_busy", 32'(bus_if.busy), 32'd1);
      reset = 1'b1;
      for (int i = 0; i < NR; i++) set_data(i, 32'hC0 + 32'(i));
      bus_if.req = 4'hF;
      tick(1);
      reset = 1'b0;
      chk("midhold_rst_busy", 32'(bus_if.busy), 32'd0);
      chk("midhold_rst_grant", 32'(bus_if.grant), 32'd0);
      push(0, 32'hC0, 0);
      wait_q(0, 20);
      bus_if.req = '0;
      tick(PERIOD + 2);

      // Read-back mismatch is sticky; flag stays clear without the option
      do_reset(1);
      bus_if.pio_readdata = 32'hDEAD_BEEF;
      set_data(0, 32'h12);
      push(0, 32'h12, 0);
      push(0, 32'h12, PERIOD);
      bus_if.req = 4'b0001;
      wait_q(0, 40);
      bus_if.req = '0;
      tick(1);
      chk("err_set", 32'(bus_if.err_mismatch), 32'(RB));
      tick(PERIOD + 2);
      chk("err_sticky", 32'(bus_if.err_mismatch), 32'(RB));
      do_reset(1);
      chk("err_cleared", 32'(bus_if.err_mismatch), 32'd0);
      bus_if.pio_readdata = 32'h34;
      set_data(1, 32'h34);
      push(1, 32'h34, 0);
      bus_if.req = 4'b0010;
      wait_q(0, 20);
      bus_if.req = '0;
      tick(PERIOD + 2);
      chk("err_match", 32'(bus_if.err_mismatch), 32'd0);
      chk("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
